// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage core: merges all stall and
// redirect sources into per-stage enables, bubble controls and one PC redirect.
module pipeline_ctrl #(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_stall,
  input  logic            br_ctrl,
  input  logic [XLEN-1:0] br_target,
  input  logic            ret_ctrl,
  input  logic [XLEN-1:0] ret_target,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            imem_ready,
  input  logic            dmem_req,
  input  logic            dmem_ready,
  input  logic            mdu_start,
  input  logic            mdu_done,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  output logic            trap_ack,
  output logic [2:0]      ctrl_state
);

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_MDU_WAIT   = 3'd1,
    ST_DMEM_WAIT  = 3'd2,
    ST_REDIR_PEND = 3'd3,
    ST_TRAP_DRAIN = 3'd4
  } state_t;

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES - 1);

  state_t          r_state;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_pc;
  logic [CW-1:0]   r_drain_cnt;

  state_t          w_state_nxt;
  logic            w_pend_valid_nxt;
  logic [XLEN-1:0] w_pend_pc_nxt;
  logic [CW-1:0]   w_drain_cnt_nxt;

  logic            w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
  logic            w_if_id_flush, w_id_ex_flush, w_ex_mem_flush;
  logic            w_redir_valid, w_trap_ack;
  logic [XLEN-1:0] w_redir_pc;
  logic            w_ctl_flow;
  logic [XLEN-1:0] w_flow_target;

  assign w_ctl_flow    = br_ctrl | ret_ctrl;
  assign w_flow_target = br_ctrl ? br_target : ret_target;

  // Redirect contract: redir_valid is a single-cycle strobe; the PC takes
  // redir_pc on that cycle and no acknowledge is returned.
  always_comb begin
    w_state_nxt      = r_state;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_pc_nxt    = r_pend_pc;
    w_drain_cnt_nxt  = r_drain_cnt;
    w_pc_en          = 1'b1;
    w_if_id_en       = 1'b1;
    w_id_ex_en       = 1'b1;
    w_ex_mem_en      = 1'b1;
    w_mem_wb_en      = 1'b1;
    w_if_id_flush    = 1'b0;
    w_id_ex_flush    = 1'b0;
    w_ex_mem_flush   = 1'b0;
    w_redir_valid    = 1'b0;
    w_redir_pc       = '0;
    w_trap_ack       = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (trap_req) begin
          w_pc_en         = 1'b0;
          w_if_id_flush   = 1'b1;
          w_id_ex_flush   = 1'b1;
          w_ex_mem_flush  = 1'b1;
          w_drain_cnt_nxt = DRAIN_INIT;
          w_state_nxt     = ST_TRAP_DRAIN;
        end else if (dmem_req && !dmem_ready) begin
          w_pc_en     = 1'b0;
          w_if_id_en  = 1'b0;
          w_id_ex_en  = 1'b0;
          w_ex_mem_en = 1'b0;
          w_mem_wb_en = 1'b0;
          // A branch resolving under a data stall is replayed once memory returns.
          if (w_ctl_flow) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_pc_nxt    = w_flow_target;
          end
          w_state_nxt = ST_DMEM_WAIT;
        end else if (mdu_start && !mdu_done) begin
          w_pc_en        = 1'b0;
          w_if_id_en     = 1'b0;
          w_id_ex_en     = 1'b0;
          w_ex_mem_flush = 1'b1;
          w_state_nxt    = ST_MDU_WAIT;
        end else if (w_ctl_flow) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          if (imem_ready) begin
            w_redir_valid = 1'b1;
            w_redir_pc    = w_flow_target;
          end else begin
            w_pc_en          = 1'b0;
            w_pend_valid_nxt = 1'b1;
            w_pend_pc_nxt    = w_flow_target;
            w_state_nxt      = ST_REDIR_PEND;
          end
        end else if (load_stall) begin
          w_pc_en       = 1'b0;
          w_if_id_en    = 1'b0;
          w_id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          w_pc_en       = 1'b0;
          w_if_id_flush = 1'b1;
        end
      end

      ST_DMEM_WAIT: begin
        if (!dmem_ready) begin
          w_pc_en     = 1'b0;
          w_if_id_en  = 1'b0;
          w_id_ex_en  = 1'b0;
          w_ex_mem_en = 1'b0;
          w_mem_wb_en = 1'b0;
        end else begin
          if (r_pend_valid) begin
            w_redir_valid = 1'b1;
            w_redir_pc    = r_pend_pc;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end
          w_pend_valid_nxt = 1'b0;
          w_state_nxt      = ST_RUN;
        end
      end

      ST_MDU_WAIT: begin
        if (!mdu_done) begin
          w_pc_en        = 1'b0;
          w_if_id_en     = 1'b0;
          w_id_ex_en     = 1'b0;
          w_ex_mem_flush = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end

      ST_REDIR_PEND: begin
        w_pc_en       = 1'b0;
        w_if_id_flush = 1'b1;
        if (imem_ready) begin
          w_redir_valid    = 1'b1;
          w_redir_pc       = r_pend_pc;
          w_pc_en          = 1'b1;
          w_pend_valid_nxt = 1'b0;
          w_state_nxt      = ST_RUN;
        end
      end

      ST_TRAP_DRAIN: begin
        w_pc_en        = 1'b0;
        w_if_id_flush  = 1'b1;
        w_id_ex_flush  = 1'b1;
        w_ex_mem_flush = 1'b1;
        w_mem_wb_en    = 1'b1;
        if (r_drain_cnt != '0) begin
          w_drain_cnt_nxt = r_drain_cnt - CW'(1);
        end else if (imem_ready) begin
          w_redir_valid = 1'b1;
          w_redir_pc    = trap_vec;
          w_trap_ack    = 1'b1;
          w_state_nxt   = ST_RUN;
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
      r_drain_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_pc    <= w_pend_pc_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
    end
  end

  // Outputs are forced quiet while reset is held so nothing advances.
  assign pc_en        = rst_n & w_pc_en;
  assign if_id_en     = rst_n & w_if_id_en;
  assign id_ex_en     = rst_n & w_id_ex_en;
  assign ex_mem_en    = rst_n & w_ex_mem_en;
  assign mem_wb_en    = rst_n & w_mem_wb_en;
  assign if_id_flush  = rst_n & w_if_id_flush;
  assign id_ex_flush  = rst_n & w_id_ex_flush;
  assign ex_mem_flush = rst_n & w_ex_mem_flush;
  assign redir_valid  = rst_n & w_redir_valid;
  assign trap_ack     = rst_n & w_trap_ack;
  assign redir_pc     = rst_n ? w_redir_pc : '0;
  assign ctrl_state   = rst_n ? r_state : 3'd0;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Table-driven bench for pipeline_ctrl: each vector's expected outputs go
// through a scoreboard queue and are compared half a cycle after driving.
module tb_pipeline_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_stall, br_ctrl, ret_ctrl, trap_req;
  logic            imem_ready, dmem_req, dmem_ready, mdu_start, mdu_done;
  logic [XLEN-1:0] br_target, ret_target, trap_vec;
  logic            pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic            if_id_flush, id_ex_flush, ex_mem_flush;
  logic            redir_valid, trap_ack;
  logic [XLEN-1:0] redir_pc;
  logic [2:0]      ctrl_state;

  pipeline_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_stall(load_stall),
    .br_ctrl(br_ctrl), .br_target(br_target),
    .ret_ctrl(ret_ctrl), .ret_target(ret_target),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .trap_ack(trap_ack), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  // Input order: {load_stall, br, ret, trap, imem_ready, dmem_req, dmem_ready, mdu_start, mdu_done}
  localparam logic [8:0] I_IDLE     = 9'b000010000;
  localparam logic [8:0] I_MISS     = 9'b000000000;
  localparam logic [8:0] I_LS       = 9'b100010000;
  localparam logic [8:0] I_BR       = 9'b010010000;
  localparam logic [8:0] I_RET      = 9'b001010000;
  localparam logic [8:0] I_BRRET    = 9'b011010000;
  localparam logic [8:0] I_LS_BR    = 9'b110010000;
  localparam logic [8:0] I_BRMISS   = 9'b010000000;
  localparam logic [8:0] I_DW_BR    = 9'b011011000;
  localparam logic [8:0] I_DW       = 9'b000011000;
  localparam logic [8:0] I_DRDY     = 9'b000011100;
  localparam logic [8:0] I_MDU      = 9'b000010010;
  localparam logic [8:0] I_MDU_TRAP = 9'b000110010;
  localparam logic [8:0] I_MDONE    = 9'b000010011;
  localparam logic [8:0] I_TRAP     = 9'b000110000;
  localparam logic [8:0] I_TRAP_ALL = 9'b010111000;

  // Output order: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes, redir_valid, trap_ack}
  localparam logic [9:0] C_RUN     = 10'b11111_000_00;
  localparam logic [9:0] C_LS      = 10'b00111_010_00;
  localparam logic [9:0] C_REDIR   = 10'b11111_110_10;
  localparam logic [9:0] C_MISS    = 10'b01111_100_00;
  localparam logic [9:0] C_BRMISS  = 10'b01111_110_00;
  localparam logic [9:0] C_FREEZE  = 10'b00000_000_00;
  localparam logic [9:0] C_MDU     = 10'b00011_001_00;
  localparam logic [9:0] C_TRAP    = 10'b01111_111_00;
  localparam logic [9:0] C_TRAP_RD = 10'b01111_111_11;
  localparam logic [9:0] C_PEND_RD = 10'b11111_000_10;
  localparam logic [9:0] M_ALL     = 10'b11111_111_11;
  localparam logic [9:0] M_NOPC    = 10'b01111_111_11;
  localparam logic [9:0] M_NOIFFL  = 10'b11111_011_11;

  typedef struct {
    logic [8:0]      in;
    logic [9:0]      ctl;
    logic [9:0]      mask;
    logic [XLEN-1:0] pc;
    logic [2:0]      st;
  } vec_t;

  vec_t        vecs[$];
  logic [54:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic add_vec(input logic [8:0] in, input logic [9:0] ctl, input logic [9:0] mask,
                         input logic [XLEN-1:0] pc, input logic [2:0] st);
    vec_t v;
    v.in = in; v.ctl = ctl; v.mask = mask; v.pc = pc; v.st = st;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [8:0] in);
    {load_stall, br_ctrl, ret_ctrl, trap_req, imem_ready,
     dmem_req, dmem_ready, mdu_start, mdu_done} = in;
  endtask

  task automatic check_out(input string name);
    logic [54:0]     e;
    logic [9:0]      ectl, emask, act;
    logic [XLEN-1:0] epc;
    logic [2:0]      est;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    n_pass++;
    e = exp_q.pop_front();
    {ectl, emask, epc, est} = e;
    act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, redir_valid, trap_ack};
    n_checks++;
    if ((act & emask) === (ectl & emask)) n_pass++;
    else $display("FAIL %s ctl: got %b want %b (mask %b)", name, act, ectl, emask);
    n_checks++;
    if (redir_pc === epc) n_pass++;
    else $display("FAIL %s redir_pc: got %h want %h", name, redir_pc, epc);
    n_checks++;
    if (ctrl_state === est) n_pass++;
    else $display("FAIL %s state: got %0d want %0d", name, ctrl_state, est);
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v.in);
    exp_q.push_back({v.ctl, v.mask, v.pc, v.st});
    @(negedge clk);
    check_out(name);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_raw(input logic [8:0] in, input logic [9:0] ctl, input logic [9:0] mask,
                           input logic [XLEN-1:0] pc, input logic [2:0] st, input string name);
    vec_t v;
    v.in = in; v.ctl = ctl; v.mask = mask; v.pc = pc; v.st = st;
    apply(v, name);
  endtask

  initial begin
    br_target  = 32'h0000_0080;
    ret_target = 32'h0000_0200;
    trap_vec   = 32'h0000_0100;
    drive(I_IDLE);

    add_vec(I_IDLE,     C_RUN,     M_ALL,    32'h0,   3'd0);
    add_vec(I_LS,       C_LS,      M_ALL,    32'h0,   3'd0);
    add_vec(I_IDLE,     C_RUN,     M_ALL,    32'h0,   3'd0);
    add_vec(I_BR,       C_REDIR,   M_ALL,    32'h80,  3'd0);
    add_vec(I_RET,      C_REDIR,   M_ALL,    32'h200, 3'd0);
    add_vec(I_BRRET,    C_REDIR,   M_ALL,    32'h80,  3'd0);
    add_vec(I_LS_BR,    C_REDIR,   M_ALL,    32'h80,  3'd0);
    add_vec(I_MISS,     C_MISS,    M_ALL,    32'h0,   3'd0);
    add_vec(I_BRMISS,   C_BRMISS,  M_ALL,    32'h0,   3'd0);
    add_vec(I_BRMISS,   C_MISS,    M_ALL,    32'h0,   3'd3);
    add_vec(I_BRMISS,   C_MISS,    M_ALL,    32'h0,   3'd3);
    add_vec(I_BR,       C_PEND_RD, M_NOIFFL, 32'h80,  3'd3);
    add_vec(I_IDLE,     C_RUN,     M_ALL,    32'h0,   3'd0);
    add_vec(I_DW_BR,    C_FREEZE,  M_ALL,    32'h0,   3'd0);
    add_vec(I_DW,       C_FREEZE,  M_ALL,    32'h0,   3'd2);
    add_vec(I_DW,       C_FREEZE,  M_ALL,    32'h0,   3'd2);
    add_vec(I_DW,       C_FREEZE,  M_ALL,    32'h0,   3'd2);
    add_vec(I_DRDY,     C_REDIR,   M_ALL,    32'h80,  3'd2);
    add_vec(I_IDLE,     C_RUN,     M_ALL,    32'h0,   3'd0);
    add_vec(I_DW,       C_FREEZE,  M_ALL,    32'h0,   3'd0);
    add_vec(I_DRDY,     C_RUN,     M_ALL,    32'h0,   3'd2);
    add_vec(I_IDLE,     C_RUN,     M_ALL,    32'h0,   3'd0);
    add_vec(I_MDU,      C_MDU,     M_ALL,    32'h0,   3'd0);
    add_vec(I_MDU_TRAP, C_MDU,     M_ALL,    32'h0,   3'd1);
    add_vec(I_MDU,      C_MDU,     M_ALL,    32'h0,   3'd1);
    add_vec(I_MDU,      C_MDU,     M_ALL,    32'h0,   3'd1);
    add_vec(I_MDU,      C_MDU,     M_ALL,    32'h0,   3'd1);
    add_vec(I_MDONE,    C_RUN,     M_ALL,    32'h0,   3'd1);
    add_vec(I_IDLE,     C_RUN,     M_ALL,    32'h0,   3'd0);
    add_vec(I_TRAP,     C_TRAP,    M_ALL,    32'h0,   3'd0);
    add_vec(I_IDLE,     C_TRAP,    M_ALL,    32'h0,   3'd4);
    add_vec(I_IDLE,     C_TRAP_RD, M_NOPC,   32'h100, 3'd4);
    add_vec(I_IDLE,     C_RUN,     M_ALL,    32'h0,   3'd0);
    add_vec(I_TRAP_ALL, C_TRAP,    M_ALL,    32'h0,   3'd0);
    add_vec(I_MISS,     C_TRAP,    M_ALL,    32'h0,   3'd4);
    add_vec(I_MISS,     C_TRAP,    M_ALL,    32'h0,   3'd4);
    add_vec(I_IDLE,     C_TRAP_RD, M_NOPC,   32'h100, 3'd4);
    add_vec(I_IDLE,     C_RUN,     M_ALL,    32'h0,   3'd0);

    // Reset held: every output must be quiet.
    exp_q.push_back({10'b0, M_ALL, 32'h0, 3'd0});
    @(negedge clk);
    check_out("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a pending redirect must discard it.
    apply_raw(I_BRMISS, C_BRMISS, M_ALL, 32'h0, 3'd0, "pend_enter");
    apply_raw(I_MISS,   C_MISS,   M_ALL, 32'h0, 3'd3, "pend_hold");
    rst_n = 1'b0;
    drive(I_BRMISS);
    exp_q.push_back({10'b0, M_ALL, 32'h0, 3'd0});
    @(negedge clk);
    check_out("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply_raw(I_IDLE, C_RUN, M_ALL, 32'h0, 3'd0, "post_rst0");
    apply_raw(I_IDLE, C_RUN, M_ALL, 32'h0, 3'd0, "post_rst1");

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d left want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V core. It merges the load-use stall from the hazard detector, branch/return redirects, MEM-stage traps, instruction/data memory wait states and the multi-cycle MUL/DIV unit. From these it drives per-stage register enables, bubble (flush) controls and a single PC redirect port. It sits beside the pipeline registers and replaces the ad-hoc OR of stall sources in the core top.

Parameters:
XLEN, 32, width of PC/target buses
DRAIN_CYCLES, 2, cycles MEM/WB keeps draining after a trap before redirect (>=1)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
load_stall  in  1  load-use stall from hazard detector
br_ctrl  in  1  taken branch/jump resolved in EX
br_target  in  XLEN  branch target
ret_ctrl  in  1  mret/ret resolved in EX
ret_target  in  XLEN  return target
trap_req  in  1  exception/interrupt taken at MEM
trap_vec  in  XLEN  trap handler address
imem_ready  in  1  fetch data valid this cycle
dmem_req  in  1  MEM stage performing load/store
dmem_ready  in  1  data access completes this cycle
mdu_start  in  1  EX holds MUL/DIV op
mdu_done  in  1  MDU result valid
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load bubble into that register
redir_valid  out  1  load PC from redir_pc
redir_pc  out  XLEN  redirect address
trap_ack  out  1  one-cycle pulse when trap redirect issued
ctrl_state  out  3  FSM state, debug

Behaviour:
- State register with async clear: RUN=0, MDU_WAIT=1, DMEM_WAIT=2, REDIR_PEND=3, TRAP_DRAIN=4. Pending-redirect register: pend_valid, pend_pc. Drain counter.
- Reset values: while rst_n=0 the state is RUN and pend_valid, pend_pc and the counter are 0. All enables, flushes, redir_valid and trap_ack are 0, redir_pc is 0, ctrl_state is 0.
- Outputs are combinational from state, registers and inputs, so there is zero-cycle response. Default outputs: all enables 1, flushes 0.
- RUN sources, highest priority first:
  1. trap_req: pc_en=0; all three flushes=1; counter<=DRAIN_CYCLES-1; go TRAP_DRAIN.
  2. dmem_req & !dmem_ready: all enables 0. If br_ctrl|ret_ctrl, capture pend_pc. Go DMEM_WAIT.
  3. mdu_start & !mdu_done: pc_en, if_id_en and id_ex_en are 0; ex_mem_flush=1. Go MDU_WAIT.
  4. br_ctrl|ret_ctrl (br_ctrl wins if both): if_id_flush=id_ex_flush=1.
     - If imem_ready: redir_valid=1, redir_pc=target.
     - Else: pc_en=0, capture pend_pc, go REDIR_PEND.
  5. load_stall: pc_en=0, if_id_en=0, id_ex_flush=1.
  6. !imem_ready: pc_en=0, if_id_flush=1.
- DMEM_WAIT: all enables 0 until dmem_ready. On the dmem_ready cycle, all enables are 1.
  - If pend_valid: redir_valid=1 with pend_pc, if_id_flush=id_ex_flush=1, then clear pend_valid.
  - Return to RUN.
- MDU_WAIT: same freeze as RUN priority 3 until mdu_done. On mdu_done, all enables are 1 and the state returns to RUN.
- REDIR_PEND: pc_en=0, if_id_flush=1. On imem_ready: redir_valid=1, redir_pc=pend_pc, pc_en=1, clear pend_valid, go RUN.
- TRAP_DRAIN: pc_en=0, all three flushes=1, mem_wb_en=1. The counter decrements each cycle.
  - When the counter is 0 and imem_ready: redir_valid=1, redir_pc=trap_vec, trap_ack=1, go RUN.
  - While the counter is 0 and !imem_ready, wait in TRAP_DRAIN.
- trap_req, br_ctrl, ret_ctrl, load_stall and mdu_start are ignored outside RUN, except for the br/ret capture in priority 2.
- Reset asserted mid-sequence discards pending redirects and returns to RUN immediately.
- redir_valid is never asserted for more than one cycle per event.

Test Plan:
- Load-use: load_stall=1 for 1 cycle, imem_ready=1 -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; all enables 1 the next cycle.
- Branch during fetch miss: br_ctrl=1, br_target=0x80, imem_ready=0 for 3 cycles -> state=3, pc_en=0 for 3 cycles. The cycle imem_ready=1: redir_valid=1, redir_pc=0x80, then state=0.
- DMEM wait with branch: dmem_req=1, dmem_ready=0 for 4 cycles, br_ctrl=1 and ret_ctrl=1 in the first cycle -> all enables 0 for 4 cycles. On ready: redir_pc=br_target (not ret_target), single redir_valid pulse.
- MDU: mdu_start=1, mdu_done after 5 cycles -> ex_mem_flush=1 and pc_en=0 for 5 cycles. On done, all enables 1 and state=0.
- Trap: trap_req=1, trap_vec=0x100, DRAIN_CYCLES=2 -> state=4 for 2 cycles with mem_wb_en=1, then redir_pc=0x100, trap_ack single pulse.
- Reset mid-REDIR_PEND: rst_n low 1 cycle -> all outputs 0, state=0; after release, no redir_valid.
